a5_keystream_fetcher: RTL and testbench
=======================================

// Module: a5_keystream_fetcher
// PURPOSE
// - Wishbone classic initiator that pulls A5/1 keystream words from the keystream slave's data register (single-word reads).
// - Buffers fetched words in a small FIFO and presents them on a valid/ready stream to downstream consumers (e.g. cipher XOR datapath).
// - Fetches a programmed number of words per start command, with ack timeout protection.
// PARAMETERS
// - KS_ADDR        32'h0  Wishbone address of the slave keystream data register.
// - FIFO_DEPTH     4      Output FIFO entries; power of 2, >= 2.
// - TIMEOUT_CYCLES 16     Max cycles in WAIT_ACK before abort; >= 2.
// PORTS
// - clk          in   1   Clock; all logic on posedge.
// - reset_n      in   1   Asynchronous, active-low reset.
// - start        in   1   One-cycle command pulse; ignored while busy=1.
// - word_count   in   16  Words to fetch, sampled when start is accepted.
// - busy         out  1   High from accepted start until done.
// - done         out  1   One-cycle pulse at end of command (normal or timeout).
// - timeout_err  out  1   Sticky; set on ack timeout, cleared by next accepted start.
// - wbm_cyc_o    out  1   Wishbone cycle.
// - wbm_stb_o    out  1   Wishbone strobe.
// - wbm_we_o     out  1   Always 0 (reads only).
// - wbm_sel_o    out  4   4'hF while stb high, else 0.
// - wbm_adr_o    out  32  KS_ADDR while stb high, else 0.
// - wbm_dat_i    in   32  Read data; valid when wbm_ack_i=1.
// - wbm_ack_i    in   1   Slave acknowledge.
// - ks_data      out  32  FIFO head word (first-word fall-through).
// - ks_valid     out  1   FIFO non-empty.
// - ks_ready     in   1   Consumer accepts head when ks_valid & ks_ready.
// BEHAVIOUR
// - Reset: state IDLE; busy, done, timeout_err, cyc, stb, sel, adr = 0; FIFO empty (ks_valid=0, ks_data=0); remaining=0.
// - All Wishbone outputs are registered; cyc_o == stb_o at all times.
// - IDLE: start & word_count!=0 -> load remaining, clear timeout_err, busy=1, -> ISSUE.
//   start & word_count==0 -> done pulse next cycle, busy stays 0, timeout_err cleared.
// - ISSUE: if FIFO free slots > 0, assert cyc/stb -> WAIT_ACK; else hold (stb low) until a pop frees a slot.
// - WAIT_ACK: stb held; timeout counter increments each cycle.
//   ack_i=1 -> push wbm_dat_i into FIFO, drop cyc/stb on the next edge, remaining -= 1;
//   remaining hits 0 -> IDLE with done pulse, busy=0; else -> GAP.
//   counter reaches TIMEOUT_CYCLES without ack -> drop cyc/stb, set timeout_err, done pulse, busy=0, -> IDLE; remaining discarded.
// - GAP: exactly one cycle with stb low, so the slave's registered ack deasserts; -> ISSUE.
// - Min throughput: one word per 4 cycles against a slave with 1-cycle registered ack.
// - ack_i outside WAIT_ACK is ignored (no push).
// - FIFO: push and pop in the same cycle are allowed even when full or empty-with-push-only.
//   ISSUE only proceeds with a free slot, so a push never overflows.
//   ks_data holds the head; it is undefined-but-stable (last value) when empty.
// - FIFO contents persist across commands; only reset flushes.
// - start while busy is ignored: no reload, no error.
// - Counters: remaining is 16 bits; timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and clears on entry to WAIT_ACK.
// STRUCTURE
// - Shared package a5_pkg:
//   - fetcher state enum {IDLE, ISSUE, WAIT_ACK, GAP};
//   - WB_SEL_ALL = 4'hF;
//   - KS_DATA_ADDR = 32'h0 (also used by the slave decode).
// - One sub-module: a5_ks_fifo
//   - synchronous FWFT FIFO; params WIDTH, DEPTH;
//   - ports push/din/pop/dout/empty/full/count.
// - Top holds the FSM, counters and Wishbone registers.
// TESTING
// - Reset mid-WAIT_ACK: assert reset_n=0 with stb high -> cyc/stb/busy drop asynchronously, ks_valid=0, no done pulse.
// - Normal fetch: start, word_count=3, slave acks 1 cycle after stb with 32'hA5A50001..3, ks_ready=1 ->
//   three words out in order; done pulses once; busy low after; timeout_err=0.
// - Backpressure: word_count=6, FIFO_DEPTH=4, ks_ready=0 -> exactly 4 reads issued, stb stays low;
//   raise ks_ready -> remaining 2 reads issue; 6 words delivered in order.
// - Timeout: slave never acks, word_count=2 -> stb high exactly TIMEOUT_CYCLES cycles then drops;
//   timeout_err=1, done pulse, busy=0; next start with word_count=1 clears timeout_err.
// - Zero count and ignored start:
//   - word_count=0 -> done pulse, no cyc;
//   - start pulsed while busy with word_count=5 -> original count (2) fetched only.
// - Ack protocol: slave holding ack_i=1 for 2 cycles -> only one push per transfer; GAP cycle observed between consecutive stb pulses.

Source files
------------

// File: rtl/a5_pkg.sv
// a5_pkg: shared state encoding and Wishbone constants for the A5/1 keystream path
package a5_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} fetch_state_e;
  localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
  localparam logic [31:0] KS_DATA_ADDR = 32'h0;
endpackage

// File: rtl/a5_ks_fifo.sv
// a5_ks_fifo: first-word fall-through FIFO buffering fetched keystream words
module a5_ks_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, wr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;
  assign empty   = cnt_q == '0;
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/a5_keystream_fetcher.sv
// a5_keystream_fetcher: Wishbone read initiator streaming A5/1 keystream words through a FIFO
module a5_keystream_fetcher
  import a5_pkg::*;
#(
  parameter logic [31:0] KS_ADDR        = KS_DATA_ADDR,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic [31:0] ks_data,
  output logic        ks_valid,
  input  logic        ks_ready
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_e  state_q;
  logic [15:0]   remaining_q;
  logic [TW-1:0] tcnt_q;
  logic          busy_q, done_q, terr_q, stb_q;
  logic [3:0]    sel_q;
  logic [31:0]   adr_q;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign wbm_cyc_o   = stb_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = 1'b0;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign ks_valid    = !fifo_empty;
  assign fifo_pop    = ks_valid && ks_ready;
  // Only a read issued with a free slot can be acked, so the full guard never drops data.
  assign fifo_push   = (state_q == WAIT_ACK) && wbm_ack_i && (!fifo_full || fifo_pop);
  a5_ks_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (wbm_dat_i),
    .pop     (fifo_pop),
    .dout    (ks_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      tcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      stb_q       <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          terr_q <= 1'b0;
          if (word_count != '0) begin
            remaining_q <= word_count;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end else done_q <= 1'b1;
        end
        ISSUE: if (fifo_count < CW'(FIFO_DEPTH)) begin
          stb_q   <= 1'b1;
          sel_q   <= WB_SEL_ALL;
          adr_q   <= KS_ADDR;
          tcnt_q  <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          tcnt_q <= tcnt_q + TW'(1);
          if (wbm_ack_i) begin
            stb_q       <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            remaining_q <= remaining_q - 16'd1;
            if (remaining_q == 16'd1) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else state_q <= GAP;
          end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            stb_q       <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            remaining_q <= '0;
            terr_q      <= 1'b1;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        GAP:     state_q <= ISSUE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_a5_keystream_fetcher.sv
// tb_a5_keystream_fetcher: directed checks of the keystream fetcher against a small Wishbone slave model
module tb_a5_keystream_fetcher;
  localparam int M_NORM = 0, M_NEVER = 1, M_HOLD = 2;
  logic        clk = 1'b0, reset_n, start, busy, done, timeout_err;
  logic [15:0] word_count;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, ks_valid, ks_ready;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_i, ks_data;
  int          mode, n_chk, n_fail;
  a5_keystream_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready)
  );
  always #5 clk = ~clk;
  logic [1:0]  ack_left;
  logic [31:0] idx;
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ack_left <= '0;
      idx      <= '0;
    end else begin
      if (wbm_stb_o && wbm_ack_i) idx <= idx + 1;
      if (ack_left != 0) ack_left <= ack_left - 2'd1;
      else if (wbm_stb_o && mode != M_NEVER) ack_left <= (mode == M_HOLD) ? 2'd2 : 2'd1;
    end
  assign wbm_ack_i = ack_left != 0;
  assign wbm_dat_i = 32'hA5A50001 + idx;
  int          n_done, n_rise, n_hi, n_cyc_bad, min_gap, low_run;
  logic        stb_prev, seen;
  logic [31:0] got[$];
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      n_done <= 0; n_rise <= 0; n_hi <= 0; n_cyc_bad <= 0;
      min_gap <= 255; low_run <= 0; stb_prev <= 1'b0; seen <= 1'b0;
      got.delete();
    end else begin
      n_done <= n_done + int'(done);
      n_hi   <= n_hi + int'(wbm_stb_o);
      if (wbm_cyc_o !== wbm_stb_o) n_cyc_bad <= n_cyc_bad + 1;
      if (wbm_stb_o && !stb_prev) begin
        n_rise <= n_rise + 1;
        if (seen && low_run < min_gap) min_gap <= low_run;
        seen <= 1'b1;
      end
      low_run  <= wbm_stb_o ? 0 : low_run + 1;
      stb_prev <= wbm_stb_o;
      if (ks_valid && ks_ready) got.push_back(ks_data);
    end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_words(input string tag, input int n);
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++)
      chk(tag, (i < got.size()) ? got[i] : 32'hxxxxxxxx, 32'hA5A50001 + 32'(i));
  endtask
  task automatic pulse_start(input logic [15:0] wc);
    start = 1'b1;
    word_count = wc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int target, input int max_cyc);
    int k = 0;
    while (n_done < target && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_done), 32'(target));
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    n_chk = 0; n_fail = 0; mode = M_NORM;
    reset_n = 1'b0; start = 1'b0; word_count = '0; ks_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_cyc", 32'(wbm_cyc_o), 0);
    chk("rst_stb", 32'(wbm_stb_o), 0);
    chk("rst_we", 32'(wbm_we_o), 0);
    chk("rst_sel", 32'(wbm_sel_o), 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_valid", 32'(ks_valid), 0);
    chk("rst_data", ks_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    ks_ready = 1'b1;
    pulse_start(3);
    chk("norm_busy_on", 32'(busy), 1);
    repeat (2) @(negedge clk);
    chk("norm_sel", 32'(wbm_sel_o), 32'hF);
    chk("norm_adr", wbm_adr_o, 32'h0);
    wait_done("norm_done", 1, 40);
    repeat (3) @(negedge clk);
    chk_words("norm_word", 3);
    chk("norm_done_once", 32'(n_done), 1);
    chk("norm_busy_off", 32'(busy), 0);
    chk("norm_terr", 32'(timeout_err), 0);
    chk("norm_gap", 32'(min_gap), 2);
    chk("norm_empty", 32'(ks_valid), 0);
    do_reset();
    ks_ready = 1'b0;
    pulse_start(6);
    repeat (40) @(negedge clk);
    chk("bp_reads", 32'(n_rise), 4);
    chk("bp_stb_low", 32'(wbm_stb_o), 0);
    chk("bp_busy", 32'(busy), 1);
    chk("bp_valid", 32'(ks_valid), 1);
    chk("bp_head", ks_data, 32'hA5A50001);
    ks_ready = 1'b1;
    wait_done("bp_done", 1, 60);
    repeat (3) @(negedge clk);
    chk("bp_reads_all", 32'(n_rise), 6);
    chk_words("bp_word", 6);
    chk("bp_busy_off", 32'(busy), 0);
    do_reset();
    mode = M_NEVER;
    pulse_start(2);
    wait_done("to_done", 1, 60);
    chk("to_stb_cycles", 32'(n_hi), 16);
    chk("to_reads", 32'(n_rise), 1);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_busy", 32'(busy), 0);
    chk("to_stb_low", 32'(wbm_stb_o), 0);
    repeat (5) @(negedge clk);
    chk("to_no_retry", 32'(n_rise), 1);
    mode = M_NORM;
    pulse_start(1);
    chk("to_err_clr", 32'(timeout_err), 0);
    wait_done("to_done2", 2, 40);
    repeat (3) @(negedge clk);
    chk_words("to_word", 1);
    do_reset();
    pulse_start(0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    chk("zero_no_cyc", 32'(n_rise), 0);
    chk("zero_done_once", 32'(n_done), 1);
    pulse_start(2);
    chk("ign_busy", 32'(busy), 1);
    pulse_start(5);
    wait_done("ign_done", 2, 60);
    repeat (20) @(negedge clk);
    chk("ign_reads", 32'(n_rise), 2);
    chk_words("ign_word", 2);
    chk("ign_busy_off", 32'(busy), 0);
    do_reset();
    mode = M_HOLD;
    pulse_start(3);
    wait_done("hold_done", 1, 60);
    repeat (3) @(negedge clk);
    chk_words("hold_word", 3);
    chk("hold_reads", 32'(n_rise), 3);
    chk("hold_gap", 32'(min_gap), 2);
    chk("hold_cyc_eq_stb", 32'(n_cyc_bad), 0);
    do_reset();
    mode = M_NORM;
    ks_ready = 1'b0;
    pulse_start(2);
    wait_done("mid_fill", 1, 40);
    mode = M_NEVER;
    pulse_start(1);
    repeat (2) @(negedge clk);
    chk("mid_stb_high", 32'(wbm_stb_o), 1);
    chk("mid_valid", 32'(ks_valid), 1);
    chk("mid_head", ks_data, 32'hA5A50001);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_cyc", 32'(wbm_cyc_o), 0);
    chk("mid_stb", 32'(wbm_stb_o), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_valid_off", 32'(ks_valid), 0);
    chk("mid_done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_no_done", 32'(n_done), 0);
    chk("mid_idle", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
